// File: rtl/exec_unit_md_pkg.sv
// Shared constants for the execute unit: ALU control codes, alu_op and M-op
// encodings, and the sequencing FSM state type.
package exec_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLL   = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    localparam logic [1:0] AOP_MEM    = 2'b00;
    localparam logic [1:0] AOP_BRANCH = 2'b01;
    localparam logic [1:0] AOP_RTYPE  = 2'b10;
    localparam logic [1:0] AOP_ITYPE  = 2'b11;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/exec_unit_md_if.sv
// Issue/result bus between decode and the execute unit.
interface exec_unit_md_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      func3;
    logic            func7b30;
    logic            func7b25;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            unsigned_cmp;
    logic            illegal;

    modport master (
        output in_valid, alu_op, func3, func7b30, func7b25, op_a, op_b, flush,
        input  in_ready, out_valid, result, zero, unsigned_cmp, illegal
    );

    modport slave (
        input  in_valid, alu_op, func3, func7b30, func7b25, op_a, op_b, flush,
        output in_ready, out_valid, result, zero, unsigned_cmp, illegal
    );
endinterface

// File: rtl/exec_unit_md_md_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and special cases on the output.
module md_iter
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            run_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_c_o,
    output logic [XLEN-1:0] res_c_o
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned W2    = 2 * XLEN;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, dvs_q;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic            a_neg_q, b_neg_q, bz_q, ovf_q;

    logic            a_s, b_s, a_neg, b_neg;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] q_fix, r_fix;

    // Operand signedness per op; unsigned low-half mul gives the same bits.
    always_comb begin
        a_s = 1'b0;
        b_s = 1'b0;
        case (op_i)
            M_MULH:                       begin a_s = 1'b1; b_s = 1'b1; end
            M_MULHSU:                     a_s = 1'b1;
            M_DIV, M_REM:                 begin a_s = 1'b1; b_s = 1'b1; end
            M_MUL, M_MULHU, M_DIVU, M_REMU: begin a_s = 1'b0; b_s = 1'b0; end
            default:                      ;
        endcase
        a_neg = a_s & a_i[XLEN-1];
        b_neg = b_s & b_i[XLEN-1];
    end

    // One iteration: low half holds multiplier/dividend, high half the partial.
    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (XLEN+1)'(acc_q[0] ? dvs_q : '0);
        div_trial = acc_q[W2-1:XLEN-1] - {1'b0, dvs_q};
        if (op_q[2]) begin
            if (!div_trial[XLEN]) acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else                  acc_d = {acc_q[W2-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            dvs_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            bz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start_i) begin
            op_q    <= op_i;
            a_q     <= a_i;
            dvs_q   <= b_neg ? -b_i : b_i;
            acc_q   <= {{XLEN{1'b0}}, (a_neg ? -a_i : a_i)};
            cnt_q   <= CNT_W'(XLEN - 1);
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            bz_q    <= (b_i == '0);
            ovf_q   <= a_s && b_s && op_i[2] &&
                       (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        end else if (run_i) begin
            acc_q <= acc_d;
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_c_o = (cnt_q == '0);

    // Sign correction, half select and divide special cases.
    always_comb begin
        prod  = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        q_fix = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        r_fix = a_neg_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
        case (op_q)
            M_MUL:                    res_c_o = prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: res_c_o = prod[W2-1:XLEN];
            M_DIV, M_DIVU:            res_c_o = bz_q ? '1 : (ovf_q ? a_q : q_fix);
            default:                  res_c_o = bz_q ? a_q : (ovf_q ? '0 : r_fix);
        endcase
    end

endmodule

// File: rtl/exec_unit_md.sv
// Execute unit: ALU-control decode, single-cycle ALU and sequencing of the
// iterative M-extension engine, with registered result outputs.
module exec_unit_md
    import exec_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned SHAMT_W  = $clog2(XLEN)
) (
    input  logic     clk,
    input  logic     rst_n,
    exec_unit_md_if.slave eu
);
    state_e          state_q, state_d;
    logic            in_ready_q, out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d, ucmp_q, ucmp_d, illegal_q, illegal_d;

    logic [3:0]         ctrl;
    logic               dec_ill, is_m, ill_op, accept, md_start, md_run, md_last;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res, alu_val, md_res;

    // ALU control decode.
    always_comb begin
        ctrl    = ALU_ADD;
        dec_ill = 1'b0;
        is_m    = 1'b0;
        case (eu.alu_op)
            AOP_MEM:    ctrl = ALU_ADD;
            AOP_BRANCH: ctrl = ALU_SUB;
            AOP_RTYPE: begin
                if (eu.func7b25) begin
                    is_m = 1'b1;
                end else begin
                    case ({eu.func7b30, eu.func3})
                        4'b0000: ctrl = ALU_ADD;
                        4'b1000: ctrl = ALU_SUB;
                        4'b0111: ctrl = ALU_AND;
                        4'b0110: ctrl = ALU_OR;
                        4'b0001: ctrl = ALU_SLL;
                        4'b0010: ctrl = ALU_SLT;
                        4'b0011: ctrl = ALU_SLTU;
                        4'b0100: ctrl = ALU_XOR;
                        4'b0101: ctrl = ALU_SRL;
                        4'b1101: ctrl = ALU_SRA;
                        4'b1100: ctrl = ALU_PASSB;
                        default: dec_ill = 1'b1;
                    endcase
                end
            end
            default: begin
                case (eu.func3)
                    3'b000:  ctrl = ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = eu.func7b30 ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
            end
        endcase
        ill_op = dec_ill | (is_m & !ENABLE_M);
    end

    assign shamt = eu.op_b[SHAMT_W-1:0];

    always_comb begin
        case (ctrl)
            ALU_AND:   alu_res = eu.op_a & eu.op_b;
            ALU_OR:    alu_res = eu.op_a | eu.op_b;
            ALU_ADD:   alu_res = eu.op_a + eu.op_b;
            ALU_SLL:   alu_res = eu.op_a << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(eu.op_a) < $signed(eu.op_b)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, eu.op_a < eu.op_b};
            ALU_SUB:   alu_res = eu.op_a - eu.op_b;
            ALU_XOR:   alu_res = eu.op_a ^ eu.op_b;
            ALU_SRL:   alu_res = eu.op_a >> shamt;
            ALU_SRA:   alu_res = $signed(eu.op_a) >>> shamt;
            ALU_PASSB: alu_res = eu.op_b;
            default:   alu_res = '0;
        endcase
        alu_val = ill_op ? '0 : alu_res;
    end

    md_iter #(.XLEN(XLEN)) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .run_i    (md_run),
        .op_i     (eu.func3),
        .a_i      (eu.op_a),
        .b_i      (eu.op_b),
        .last_c_o (md_last),
        .res_c_o  (md_res)
    );

    assign accept = eu.in_valid && in_ready_q && !eu.flush;

    // Next-state and output-register logic; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = 1'b0;
        illegal_d   = 1'b0;
        ucmp_d      = ucmp_q;
        md_start    = 1'b0;
        md_run      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_m && ENABLE_M) begin
                        md_start = 1'b1;
                        state_d  = eu.func3[2] ? ST_DIV : ST_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_val;
                        zero_d      = (alu_val == '0);
                        illegal_d   = ill_op;
                        ucmp_d      = (eu.alu_op == AOP_BRANCH) && (eu.func3[2:1] == 2'b11);
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                md_run = 1'b1;
                if (md_last) state_d = ST_FIX;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                result_d    = md_res;
                zero_d      = (md_res == '0);
                ucmp_d      = 1'b0;
            end
        endcase
        if (eu.flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            result_d    = result_q;
            zero_d      = 1'b0;
            illegal_d   = 1'b0;
            ucmp_d      = ucmp_q;
            md_start    = 1'b0;
            md_run      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ucmp_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ucmp_q      <= ucmp_d;
            illegal_q   <= illegal_d;
        end
    end

    assign eu.in_ready     = in_ready_q;
    assign eu.out_valid    = out_valid_q;
    assign eu.result       = result_q;
    assign eu.zero         = zero_q;
    assign eu.unsigned_cmp = ucmp_q;
    assign eu.illegal      = illegal_q;

endmodule

// File: tb/tb_exec_unit_md.sv
// Directed bench for exec_unit_md: 32-bit and 64-bit units with M enabled and
// a 32-bit unit with M disabled.
module tb_exec_unit_md;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exec_unit_md_if #(.XLEN(32)) if32 ();
    exec_unit_md_if #(.XLEN(64)) if64 ();
    exec_unit_md_if #(.XLEN(32)) ifn ();

    exec_unit_md #(.XLEN(32), .ENABLE_M(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .eu(if32));
    exec_unit_md #(.XLEN(64), .ENABLE_M(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .eu(if64));
    exec_unit_md #(.XLEN(32), .ENABLE_M(1'b0)) dutn  (.clk(clk), .rst_n(rst_n), .eu(ifn));

    // Present one op to the 32-bit unit; returns at the negedge of cycle N+1.
    task automatic issue32(input logic [1:0] op, input logic b30, input logic b25,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if32.alu_op = op; if32.func7b30 = b30; if32.func7b25 = b25;
        if32.func3 = f3; if32.op_a = a; if32.op_b = b; if32.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        if32.in_valid = 1'b0;
    endtask

    // Issue an M-op and wait (bounded) for out_valid; lat=0 means timeout.
    task automatic run_m32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output bit ready_low);
        lat = 0; ready_low = 1'b1;
        issue32(2'b10, 1'b0, 1'b1, f3, a, b);
        for (int k = 1; k <= 100; k++) begin
            if (if32.out_valid === 1'b1) begin lat = k; break; end
            if (if32.in_ready !== 1'b0) ready_low = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_m64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                           output int lat, output bit ready_low);
        lat = 0; ready_low = 1'b1;
        if64.alu_op = 2'b10; if64.func7b30 = 1'b0; if64.func7b25 = 1'b1;
        if64.func3 = f3; if64.op_a = a; if64.op_b = b; if64.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        if64.in_valid = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            if (if64.out_valid === 1'b1) begin lat = k; break; end
            if (if64.in_ready !== 1'b0) ready_low = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({if32.out_valid, if32.zero, if32.unsigned_cmp, if32.illegal} !== 4'b0 || if32.result !== 32'h0) begin
            failures++;
            $display("FAIL reset32_outputs: got v=%b z=%b u=%b i=%b r=%h want all zero",
                     if32.out_valid, if32.zero, if32.unsigned_cmp, if32.illegal, if32.result);
        end
        checks++;
        if (if32.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset32_in_ready: got %b want 1", if32.in_ready);
        end
        checks++;
        if (if64.out_valid !== 1'b0 || if64.result !== 64'h0 || if64.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset64: got v=%b r=%h rdy=%b want 0/0/1", if64.out_valid, if64.result, if64.in_ready);
        end
    endtask

    task automatic test_back_to_back;
        if32.alu_op = 2'b00; if32.func3 = 3'b000; if32.func7b30 = 1'b0; if32.func7b25 = 1'b0;
        if32.op_a = 32'd5; if32.op_b = 32'd7; if32.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (if32.out_valid !== 1'b1 || if32.result !== 32'd12 || if32.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_add: got v=%b r=%h rdy=%b want 1/0000000c/1", if32.out_valid, if32.result, if32.in_ready);
        end
        if32.alu_op = 2'b01;
        @(posedge clk); @(negedge clk);
        if32.in_valid = 1'b0;
        checks++;
        if (if32.out_valid !== 1'b1 || if32.result !== 32'hFFFF_FFFE || if32.in_ready !== 1'b1 ||
            if32.unsigned_cmp !== 1'b0) begin
            failures++;
            $display("FAIL b2b_sub: got v=%b r=%h rdy=%b u=%b want 1/fffffffe/1/0",
                     if32.out_valid, if32.result, if32.in_ready, if32.unsigned_cmp);
        end
        @(negedge clk);
        checks++;
        if (if32.out_valid !== 1'b0 || if32.result !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL b2b_hold: got v=%b r=%h want 0/fffffffe", if32.out_valid, if32.result);
        end
    endtask

    task automatic test_shift_cmp;
        issue32(2'b10, 1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'd4);
        checks++;
        if (if32.out_valid !== 1'b1 || if32.result !== 32'hF800_0000 || if32.illegal !== 1'b0) begin
            failures++;
            $display("FAIL sra: got v=%b r=%h i=%b want 1/f8000000/0", if32.out_valid, if32.result, if32.illegal);
        end
        issue32(2'b11, 1'b0, 1'b0, 3'b101, 32'h8000_0000, 32'd4);
        checks++;
        if (if32.result !== 32'h0800_0000) begin
            failures++; $display("FAIL srli: got %h want 08000000", if32.result);
        end
        issue32(2'b10, 1'b0, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (if32.result !== 32'd1 || if32.zero !== 1'b0) begin
            failures++; $display("FAIL slt: got r=%h z=%b want 00000001/0", if32.result, if32.zero);
        end
        issue32(2'b10, 1'b0, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (if32.result !== 32'd0 || if32.zero !== 1'b1) begin
            failures++; $display("FAIL sltu: got r=%h z=%b want 00000000/1", if32.result, if32.zero);
        end
        issue32(2'b01, 1'b0, 1'b0, 3'b110, 32'd3, 32'd3);
        checks++;
        if (if32.unsigned_cmp !== 1'b1 || if32.zero !== 1'b1) begin
            failures++; $display("FAIL bltu_flags: got u=%b z=%b want 1/1", if32.unsigned_cmp, if32.zero);
        end
    endtask

    task automatic test_mul;
        int lat; bit rl;
        run_m32(3'b000, 32'd7, 32'hFFFF_FFFD, lat, rl);
        checks++;
        if (lat !== 34 || rl !== 1'b1) begin
            failures++; $display("FAIL mul_timing: got lat=%0d ready_low=%b want 34/1", lat, rl);
        end
        checks++;
        if (if32.result !== 32'hFFFF_FFEB) begin
            failures++; $display("FAIL mul: got %h want ffffffeb", if32.result);
        end
        run_m32(3'b001, 32'd7, 32'hFFFF_FFFD, lat, rl);
        checks++;
        if (lat !== 34 || if32.result !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL mulh: got lat=%0d r=%h want 34/ffffffff", lat, if32.result);
        end
        run_m32(3'b011, 32'hFFFF_FFFF, 32'd2, lat, rl);
        checks++;
        if (if32.result !== 32'd1) begin
            failures++; $display("FAIL mulhu: got %h want 00000001", if32.result);
        end
        run_m32(3'b010, 32'hFFFF_FFFF, 32'd2, lat, rl);
        checks++;
        if (if32.result !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL mulhsu: got %h want ffffffff", if32.result);
        end
    endtask

    task automatic test_div;
        int lat; bit rl;
        logic [2:0]  f3s  [7] = '{3'b100, 3'b110, 3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
        logic [31:0] as   [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] bs   [7] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exps [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            run_m32(f3s[i], as[i], bs[i], lat, rl);
            checks++;
            if (lat !== 34 || rl !== 1'b1 || if32.result !== exps[i]) begin
                failures++;
                $display("FAIL div_case%0d: got lat=%0d ready_low=%b r=%h want 34/1/%h",
                         i, lat, rl, if32.result, exps[i]);
            end
        end
    endtask

    task automatic test_flush;
        bit seen = 1'b0;
        issue32(2'b10, 1'b0, 1'b1, 3'b100, 32'd100, 32'd7);
        for (int k = 1; k < 10; k++) @(negedge clk);
        if32.flush = 1'b1;
        @(posedge clk); @(negedge clk);
        if32.flush = 1'b0;
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_idle: got rdy=%b v=%b want 1/0", if32.in_ready, if32.out_valid);
        end
        for (int k = 0; k < 40; k++) begin
            if (if32.out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL flush_no_result: got out_valid seen=%b want 0", seen);
        end
        issue32(2'b00, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1);
        checks++;
        if (if32.out_valid !== 1'b1 || if32.result !== 32'd2) begin
            failures++; $display("FAIL flush_then_add: got v=%b r=%h want 1/00000002", if32.out_valid, if32.result);
        end
        if32.op_a = 32'd9; if32.in_valid = 1'b1; if32.flush = 1'b1;
        @(posedge clk); @(negedge clk);
        if32.in_valid = 1'b0; if32.flush = 1'b0;
        checks++;
        if (if32.out_valid !== 1'b0 || if32.result !== 32'd2) begin
            failures++; $display("FAIL flush_drops_input: got v=%b r=%h want 0/00000002", if32.out_valid, if32.result);
        end
    endtask

    task automatic test_illegal;
        issue32(2'b10, 1'b1, 1'b0, 3'b111, 32'd5, 32'd6);
        checks++;
        if (if32.out_valid !== 1'b1 || if32.illegal !== 1'b1 || if32.result !== 32'd0) begin
            failures++;
            $display("FAIL illegal_rtype: got v=%b i=%b r=%h want 1/1/00000000", if32.out_valid, if32.illegal, if32.result);
        end
        ifn.alu_op = 2'b10; ifn.func7b30 = 1'b0; ifn.func7b25 = 1'b1; ifn.func3 = 3'b000;
        ifn.op_a = 32'd7; ifn.op_b = 32'd3; ifn.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        ifn.in_valid = 1'b0;
        checks++;
        if (ifn.out_valid !== 1'b1 || ifn.illegal !== 1'b1 || ifn.result !== 32'd0 || ifn.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL m_disabled: got v=%b i=%b r=%h rdy=%b want 1/1/00000000/1",
                     ifn.out_valid, ifn.illegal, ifn.result, ifn.in_ready);
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        issue32(2'b10, 1'b0, 1'b1, 3'b000, 32'd7, 32'd3);
        for (int k = 0; k < 5; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (if32.out_valid !== 1'b0 || if32.result !== 32'd0 || if32.illegal !== 1'b0 || if32.zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got v=%b r=%h i=%b z=%b want 0/00000000/0/0",
                     if32.out_valid, if32.result, if32.illegal, if32.zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mid_release: got rdy=%b v=%b want 1/0", if32.in_ready, if32.out_valid);
        end
        for (int k = 0; k < 40; k++) begin
            if (if32.out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_result: got out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_mul64;
        int lat; bit rl;
        run_m64(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat, rl);
        checks++;
        if (lat !== 66 || rl !== 1'b1 || if64.result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            failures++;
            $display("FAIL mul64: got lat=%0d ready_low=%b r=%h want 66/1/ffffffffffffffeb", lat, rl, if64.result);
        end
        run_m64(3'b001, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat, rl);
        checks++;
        if (if64.result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++; $display("FAIL mulh64: got %h want ffffffffffffffff", if64.result);
        end
        run_m64(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, rl);
        checks++;
        if (if64.result !== 64'd1) begin
            failures++; $display("FAIL mulhu64: got %h want 0000000000000001", if64.result);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if32.in_valid = 1'b0; if32.flush = 1'b0; if32.alu_op = 2'b00; if32.func3 = 3'b000;
        if32.func7b30 = 1'b0; if32.func7b25 = 1'b0; if32.op_a = '0; if32.op_b = '0;
        if64.in_valid = 1'b0; if64.flush = 1'b0; if64.alu_op = 2'b00; if64.func3 = 3'b000;
        if64.func7b30 = 1'b0; if64.func7b25 = 1'b0; if64.op_a = '0; if64.op_b = '0;
        ifn.in_valid = 1'b0; ifn.flush = 1'b0; ifn.alu_op = 2'b00; ifn.func3 = 3'b000;
        ifn.func7b30 = 1'b0; ifn.func7b25 = 1'b0; ifn.op_a = '0; ifn.op_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_back_to_back;
        test_shift_cmp;
        test_mul;
        test_div;
        test_flush;
        test_illegal;
        test_reset_mid;
        test_mul64;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
